// File: rtl/reg_access_sequencer_pkg.sv
// Shared constants for the register-access sequencer: operation codes, FSM
// states, register-file select codes, fixed register indices, the latched
// operation record, the registered control bundle and its state decoder.
package reg_access_sequencer_pkg;

    // Operation codes presented on OP_CODE; 6 and 7 are illegal.
    localparam logic [2:0] REGSEQ_OP_RR   = 3'd0;
    localparam logic [2:0] REGSEQ_OP_ALU  = 3'd1;
    localparam logic [2:0] REGSEQ_OP_LOAD = 3'd2;
    localparam logic [2:0] REGSEQ_OP_CALL = 3'd3;
    localparam logic [2:0] REGSEQ_OP_PUSH = 3'd4;
    localparam logic [2:0] REGSEQ_OP_RET  = 3'd5;

    // Port A address select.
    localparam logic [1:0] REGA_ADDRX_ARG = 2'd0;
    localparam logic [1:0] REGA_ADDRX_RL  = 2'd1;

    // Port A write-data select.
    localparam logic [1:0] REGA_DINX_ALU_R     = 2'd0;
    localparam logic [1:0] REGA_DINX_DIN       = 2'd1;
    localparam logic [1:0] REGA_DINX_DINH      = 2'd2;
    localparam logic [1:0] REGA_DINX_PC_A_NEXT = 2'd3;

    // Port B address select.
    localparam logic [2:0] REGB_ADDRX_ARG = 3'd0;
    localparam logic [2:0] REGB_ADDRX_RSP = 3'd1;
    localparam logic [2:0] REGB_ADDRX_RRS = 3'd2;

    // Fixed register indices behind the RL/RSP/RRS selects.
    localparam logic [3:0] REG_RL  = 4'd14;
    localparam logic [3:0] REG_RSP = 4'd15;
    localparam logic [3:0] REG_RRS = 4'd13;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_WAIT_MEM = 3'd2,
        ST_WB_A     = 3'd3,
        ST_WB_B     = 3'd4,
        ST_FAIL     = 3'd5
    } regseq_state_e;

    // Operation fields captured at acceptance.
    typedef struct packed {
        logic [2:0] code;
        logic [3:0] arga;
        logic [3:0] argb;
        logic       byte_wr;
        logic       addr0;
    } regseq_op_t;

    // Everything driven towards the register file, plus DONE/ERR.
    typedef struct packed {
        logic       done;
        logic       err;
        logic       rega_en;
        logic       rega_wen;
        logic [1:0] rega_byte_en;
        logic [3:0] arga_x;
        logic [1:0] rega_addrx;
        logic [1:0] rega_dinx;
        logic       regb_en;
        logic       regb_wen;
        logic [1:0] regb_byte_en;
        logic [3:0] argb_x;
        logic [2:0] regb_addrx;
    } regseq_ctrl_t;

    // Moore decode: control lines for a state given the latched operation.
    // Index lines mirror the address select so RL/RSP/RRS accesses carry
    // their real register number.
    function automatic regseq_ctrl_t regseq_decode(regseq_state_e st, regseq_op_t op);
        regseq_ctrl_t c;
        c = '0;
        case (st)
            ST_READ: begin
                c.done    = (op.code == REGSEQ_OP_RR) || (op.code == REGSEQ_OP_RET);
                c.regb_en = 1'b1;
                if (op.code != REGSEQ_OP_RET) begin
                    c.rega_en = 1'b1;
                    c.arga_x  = op.arga;
                end
                if (op.code == REGSEQ_OP_PUSH) begin
                    c.regb_addrx = REGB_ADDRX_RSP;
                    c.argb_x     = REG_RSP;
                end else if (op.code == REGSEQ_OP_RET) begin
                    c.regb_addrx = REGB_ADDRX_RRS;
                    c.argb_x     = REG_RRS;
                end else begin
                    c.regb_addrx = REGB_ADDRX_ARG;
                    c.argb_x     = op.argb;
                end
            end
            ST_WB_A: begin
                c.done         = 1'b1;
                c.rega_en      = 1'b1;
                c.rega_wen     = 1'b1;
                c.rega_byte_en = op.byte_wr ? 2'b01 : 2'b11;
                c.arga_x       = op.arga;
                c.rega_addrx   = REGA_ADDRX_ARG;
                if (op.code == REGSEQ_OP_CALL) begin
                    c.rega_byte_en = 2'b11;
                    c.arga_x       = REG_RL;
                    c.rega_addrx   = REGA_ADDRX_RL;
                    c.rega_dinx    = REGA_DINX_PC_A_NEXT;
                end else if (op.code == REGSEQ_OP_LOAD) begin
                    c.rega_dinx = (op.byte_wr && op.addr0) ? REGA_DINX_DINH : REGA_DINX_DIN;
                end else begin
                    c.rega_dinx = REGA_DINX_ALU_R;
                end
            end
            ST_WB_B: begin
                c.done         = 1'b1;
                c.regb_en      = 1'b1;
                c.regb_wen     = 1'b1;
                c.regb_byte_en = 2'b11;
                c.argb_x       = REG_RSP;
                c.regb_addrx   = REGB_ADDRX_RSP;
            end
            ST_FAIL: c.err = 1'b1;
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/reg_access_sequencer_timer.sv
// Memory-wait timer for the register-access sequencer.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : restart the count at zero
//   count_en  : advance the count by one this cycle
//   expired   : the current cycle is the last one allowed (count == LIMIT-1),
//               so counting once more reaches LIMIT
module reg_seq_timer #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_en) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == 8'(LIMIT - 1));

endmodule

// File: rtl/reg_access_sequencer.sv
// Register-access sequencer: accepts one operation per OP_VALID/OP_READY
// handshake and sequences the register-file port A/B controls over the
// following cycles. All outputs are registered (Moore) from the next state and
// the operation fields latched at acceptance.
//   CLK, RESET                    : clock, asynchronous active-high reset
//   OP_VALID/OP_READY, OP_*       : operation request and fields
//   MEM_ADDR0, MEM_ACK            : load byte-lane select, load data valid
//   DONE, ERR                     : completion / abort pulses
//   REGA_*, ARGA_X, REGB_*, ARGB_X: register-file port controls
module reg_access_sequencer
    import reg_access_sequencer_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       OP_VALID,
    output logic       OP_READY,
    input  logic [2:0] OP_CODE,
    input  logic [3:0] OP_ARGA,
    input  logic [3:0] OP_ARGB,
    input  logic       OP_BYTE,
    input  logic       MEM_ADDR0,
    input  logic       MEM_ACK,
    output logic       DONE,
    output logic       ERR,
    output logic       REGA_EN,
    output logic       REGA_WEN,
    output logic [1:0] REGA_BYTE_EN,
    output logic [3:0] ARGA_X,
    output logic [1:0] REGA_ADDRX,
    output logic [1:0] REGA_DINX,
    output logic       REGB_EN,
    output logic       REGB_WEN,
    output logic [1:0] REGB_BYTE_EN,
    output logic [3:0] ARGB_X,
    output logic [2:0] REGB_ADDRX
);

    regseq_state_e state_q, state_d;
    regseq_op_t    op_q, op_d;
    regseq_ctrl_t  ctrl_q, ctrl_d;
    logic          ready_q, ready_d;
    logic          timer_clear;
    logic          timer_en;
    logic          timer_expired;

    reg_seq_timer #(
        .LIMIT(MEM_TIMEOUT)
    ) u_timer (
        .clk     (CLK),
        .rst     (RESET),
        .clear   (timer_clear),
        .count_en(timer_en),
        .expired (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (OP_VALID) begin
                    op_d = '{code: OP_CODE, arga: OP_ARGA, argb: OP_ARGB,
                             byte_wr: OP_BYTE, addr0: MEM_ADDR0};
                    case (OP_CODE)
                        REGSEQ_OP_RR, REGSEQ_OP_ALU,
                        REGSEQ_OP_PUSH, REGSEQ_OP_RET: state_d = ST_READ;
                        REGSEQ_OP_LOAD: begin
                            state_d     = ST_WAIT_MEM;
                            timer_clear = 1'b1;
                        end
                        REGSEQ_OP_CALL: state_d = ST_WB_A;
                        default:        state_d = ST_FAIL;
                    endcase
                end
            end
            ST_READ: begin
                case (op_q.code)
                    REGSEQ_OP_ALU:  state_d = ST_WB_A;
                    REGSEQ_OP_PUSH: state_d = ST_WB_B;
                    default:        state_d = ST_IDLE;
                endcase
            end
            ST_WAIT_MEM: begin
                // An ACK in the final allowed cycle still wins over the timeout.
                if (MEM_ACK) begin
                    state_d = ST_WB_A;
                end else begin
                    timer_en = 1'b1;
                    if (timer_expired) begin
                        state_d = ST_FAIL;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ready_d = (state_d == ST_IDLE);
        ctrl_d  = regseq_decode(state_d, op_d);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            ctrl_q  <= '0;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ctrl_q  <= ctrl_d;
            ready_q <= ready_d;
        end
    end

    assign OP_READY     = ready_q;
    assign DONE         = ctrl_q.done;
    assign ERR          = ctrl_q.err;
    assign REGA_EN      = ctrl_q.rega_en;
    assign REGA_WEN     = ctrl_q.rega_wen;
    assign REGA_BYTE_EN = ctrl_q.rega_byte_en;
    assign ARGA_X       = ctrl_q.arga_x;
    assign REGA_ADDRX   = ctrl_q.rega_addrx;
    assign REGA_DINX    = ctrl_q.rega_dinx;
    assign REGB_EN      = ctrl_q.regb_en;
    assign REGB_WEN     = ctrl_q.regb_wen;
    assign REGB_BYTE_EN = ctrl_q.regb_byte_en;
    assign ARGB_X       = ctrl_q.argb_x;
    assign REGB_ADDRX   = ctrl_q.regb_addrx;

endmodule
